// File: rtl/axis_bram_fifo.sv
// axis_bram_fifo: BRAM-backed AXI-Stream FIFO with first-word-fall-through output.
// Define AXI_FIFO_BRAM_COUNTERS_EN to drive the space/occupied fill-level ports.
module axis_bram_fifo #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      space,
    output logic [15:0]      occupied
);

    typedef logic [SIZE-1:0] ptr_t;
    typedef logic [SIZE:0]   cnt_t;

    localparam int   DEPTH   = 1 << SIZE;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    function automatic cnt_t cnt_step(input cnt_t cnt, input logic inc, input logic dec);
        cnt_t res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + cnt_t'(1);
        end else if (dec && !inc) begin
            res = cnt - cnt_t'(1);
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    ptr_t             r_wr_ptr;
    ptr_t             r_rd_ptr;
    cnt_t             r_count;      // every word accepted and not yet popped
    cnt_t             r_mem_cnt;    // words still in the BRAM, not yet fetched
    logic [WIDTH-1:0] r_tdata_p1;
    logic [WIDTH-1:0] r_tdata_p2;
    logic             r_vld_p1;
    logic             r_vld_p2;

    logic w_flush;
    logic w_full;
    logic w_push;
    logic w_wr_en;
    logic w_pop;
    logic w_adv_p2;
    logic w_rd_en;
    cnt_t w_count_nxt;

    assign w_flush  = !reset || clear;
    // Full decision uses only the registered count, so a pop never frees a slot in the same cycle.
    assign w_full   = (r_count == DEPTH_C);
    assign w_push   = i_tvalid && !w_full;
    assign w_wr_en  = w_push && !w_flush;
    assign w_pop    = r_vld_p2 && o_tready;
    assign w_adv_p2 = r_vld_p1 && (!r_vld_p2 || w_pop);
    assign w_rd_en  = (r_mem_cnt != '0) && (!r_vld_p1 || w_adv_p2);

    assign w_count_nxt = cnt_step(r_count, w_push, w_pop);

    assign i_tready = !w_full;
    assign o_tvalid = r_vld_p2;
    assign o_tdata  = r_tdata_p2;

    // Stage p0: BRAM write port
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_tdata;
        end
    end

    // Stage p1: synchronous BRAM read into the prefetch register
    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_tdata_p1 <= r_mem[r_rd_ptr];
        end
    end

    // Stage p2: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (w_adv_p2) begin
            r_tdata_p2 <= r_tdata_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_mem_cnt <= '0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_mem_cnt <= cnt_step(r_mem_cnt, w_push, w_rd_en);
            r_count   <= w_count_nxt;

            if (w_rd_en) begin
                r_vld_p1 <= 1'b1;
            end else if (w_adv_p2) begin
                r_vld_p1 <= 1'b0;
            end

            if (w_adv_p2) begin
                r_vld_p2 <= 1'b1;
            end else if (w_pop) begin
                r_vld_p2 <= 1'b0;
            end
        end
    end

`ifdef AXI_FIFO_BRAM_COUNTERS_EN
    logic [15:0] r_occupied;
    logic [15:0] r_space;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_occupied <= '0;
            r_space    <= 16'(DEPTH);
        end else begin
            r_occupied <= 16'(w_count_nxt);
            r_space    <= 16'(DEPTH_C - w_count_nxt);
        end
    end

    assign occupied = r_occupied;
    assign space    = r_space;
`else
    assign occupied = '0;
    assign space    = '0;
`endif

`ifndef SYNTHESIS
    a_count_split: assert property (@(posedge clk) disable iff (!reset)
        r_count == r_mem_cnt + cnt_t'(r_vld_p1) + cnt_t'(r_vld_p2));
    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        r_count <= DEPTH_C);
`endif

endmodule

// File: tb/tb_axis_bram_fifo.sv
// tb_axis_bram_fifo: randomized bench for axis_bram_fifo against a timestamped queue model.
module tb_axis_bram_fifo;

    localparam int WIDTH = 32;
    localparam int SIZE  = 11;
    localparam int DEPTH = 1 << SIZE;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] i_tdata = '0;
    logic             i_tvalid = 1'b0;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tready = 1'b0;
    logic [15:0]      space;
    logic [15:0]      occupied;

    always #5 clk = ~clk;

    axis_bram_fifo #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .space    (space),
        .occupied (occupied)
    );

    // Model: each stored word remembers the edge it was written on; the head is
    // visible on the output once it is at least two edges old.
    typedef struct {
        logic [31:0] data;
        int          stamp;
    } entry_t;

    entry_t      q[$];
    int          t = 0;
    int          errors = 0;
    int          checks = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, t);
        end
    endtask

    task automatic cycle(input logic rstn, input logic clr, input logic tv,
                         input logic [31:0] td, input logic rdy);
        logic   exp_vld;
        logic   push;
        logic   pop;
        entry_t e;
        exp_vld = 1'b0;
        if (q.size() > 0) begin
            exp_vld = (q[0].stamp <= t - 2);
        end
        chk("i_tready", 32'(i_tready), 32'(q.size() < DEPTH));
        chk("o_tvalid", 32'(o_tvalid), 32'(exp_vld));
        if (exp_vld) begin
            chk("o_tdata", o_tdata, q[0].data);
        end
        if (prev_hold) begin
            chk("stall_hold", o_tdata, prev_data);
        end
`ifdef AXI_FIFO_BRAM_COUNTERS_EN
        chk("occupied", 32'(occupied), 32'(q.size()));
        chk("space", 32'(space), 32'(DEPTH - q.size()));
`else
        chk("occupied_tied", 32'(occupied), 32'd0);
        chk("space_tied", 32'(space), 32'd0);
`endif
        reset    = rstn;
        clear    = clr;
        i_tvalid = tv;
        i_tdata  = td;
        o_tready = rdy;
        push      = tv && (q.size() < DEPTH);
        pop       = exp_vld && rdy;
        prev_hold = exp_vld && !rdy && rstn && !clr;
        prev_data = o_tdata;
        @(posedge clk);
        t++;
        #1;
        if (!rstn || clr) begin
            q.delete();
        end else begin
            if (pop) begin
                void'(q.pop_front());
            end
            if (push) begin
                e.data  = td;
                e.stamp = t;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'd0, rdy);
        end
    endtask

    initial begin
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1;

        // reset state and idle
        idle(5, 1'b0);
        chk("rst_tready", 32'(i_tready), 32'd1);
        chk("rst_tvalid", 32'(o_tvalid), 32'd0);

        // 80-word burst, long wait, then a gapless drain
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'(i), 1'b0);
        end
        idle(300, 1'b0);
        chk("burst_head", o_tdata, 32'h0000_0000);
        chk("burst_vld", 32'(o_tvalid), 32'd1);
`ifdef AXI_FIFO_BRAM_COUNTERS_EN
        chk("burst_occ", 32'(occupied), 32'd80);
        chk("burst_space", 32'(space), 32'd1968);
`endif
        idle(80, 1'b1);
        idle(2, 1'b0);
        chk("drained_vld", 32'(o_tvalid), 32'd0);

        // fill to capacity, refused extra word, pop+push at full
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        end
        chk("full_tready", 32'(i_tready), 32'd0);
        d = $urandom;
        cycle(1'b1, 1'b0, 1'b1, d, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, d, 1'b1);
        chk("tready_after_pop", 32'(i_tready), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, d, 1'b0);
        chk("refull_tready", 32'(i_tready), 32'd0);

        // streaming across pointer wraps with random stalls
        for (int i = 0; i < 4000; i++) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3000; i++) begin
            cycle(1'b1, 1'b0, ($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
        end

        // clear with 50 words stored and a concurrent handshake
        idle(2100, 1'b1);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        end
        idle(5, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("clr_tvalid", 32'(o_tvalid), 32'd0);
        chk("clr_tready", 32'(i_tready), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
        idle(3, 1'b0);
        chk("clr_first_out", o_tdata, 32'hA5A5_0001);
        idle(3, 1'b1);

        // reset with 50 words stored
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        end
        idle(5, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("rst2_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst2_tready", 32'(i_tready), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'h5A5A_0002, 1'b0);
        idle(3, 1'b0);
        chk("rst2_first_out", o_tdata, 32'h5A5A_0002);
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
